control_microsequencer: RTL and testbench



---
 rtl/control_microsequencer_if.sv | 59 +++++
 rtl/control_microsequencer.sv | 127 ++++++++++++
 tb/tb_control_microsequencer.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_microsequencer_if.sv
// Signal bundle between the microsequencer, its control-store ROM and the datapath.
// master = sequencer side, slave = ROM/datapath/flag side.
interface control_microsequencer_if #(
  parameter int DATAWIDTH_MIR_DIRECTION = 6,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_DECODEROP     = 8,
  parameter int DATAWIDTH_CS_ADDRESS    = 11,
  parameter int DATAWIDTH_MICROWORD     = 41
);
  logic [DATAWIDTH_CS_ADDRESS-1:0]    CONTROL_CSAddress_OutBus;
  logic [DATAWIDTH_MICROWORD-1:0]     CONTROL_MicroWord_InBus;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] CONTROL_DirA_OutBus;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] CONTROL_DirB_OutBus;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] CONTROL_DirC_OutBus;
  logic                               CONTROL_SelectA_Out;
  logic                               CONTROL_SelectB_Out;
  logic                               CONTROL_SelectC_Out;
  logic                               CONTROL_RD_Out;
  logic [DATAWIDTH_ALU_SELECTION-1:0] CONTROL_ALUOperation_OutBus;
  logic                               CONTROL_MemRead_Out;
  logic                               CONTROL_MemWrite_Out;
  logic                               CONTROL_MemReady_In;
  logic                               CONTROL_SetCode_In;
  logic                               CONTROL_FlagN_In;
  logic                               CONTROL_FlagZ_In;
  logic                               CONTROL_FlagV_In;
  logic                               CONTROL_FlagC_In;
  logic                               CONTROL_Bit13_In;
  logic [DATAWIDTH_DECODEROP-1:0]     CONTROL_OPS_InBus;
  logic [3:0]                         CONTROL_PSR_OutBus;

  modport master (
    output CONTROL_CSAddress_OutBus,
    input  CONTROL_MicroWord_InBus,
    output CONTROL_DirA_OutBus, CONTROL_DirB_OutBus, CONTROL_DirC_OutBus,
    output CONTROL_SelectA_Out, CONTROL_SelectB_Out, CONTROL_SelectC_Out,
    output CONTROL_RD_Out, CONTROL_ALUOperation_OutBus,
    output CONTROL_MemRead_Out, CONTROL_MemWrite_Out,
    input  CONTROL_MemReady_In,
    input  CONTROL_SetCode_In, CONTROL_FlagN_In, CONTROL_FlagZ_In,
    input  CONTROL_FlagV_In, CONTROL_FlagC_In,
    input  CONTROL_Bit13_In, CONTROL_OPS_InBus,
    output CONTROL_PSR_OutBus
  );

  modport slave (
    input  CONTROL_CSAddress_OutBus,
    output CONTROL_MicroWord_InBus,
    input  CONTROL_DirA_OutBus, CONTROL_DirB_OutBus, CONTROL_DirC_OutBus,
    input  CONTROL_SelectA_Out, CONTROL_SelectB_Out, CONTROL_SelectC_Out,
    input  CONTROL_RD_Out, CONTROL_ALUOperation_OutBus,
    input  CONTROL_MemRead_Out, CONTROL_MemWrite_Out,
    output CONTROL_MemReady_In,
    output CONTROL_SetCode_In, CONTROL_FlagN_In, CONTROL_FlagZ_In,
    output CONTROL_FlagV_In, CONTROL_FlagC_In,
    output CONTROL_Bit13_In, CONTROL_OPS_InBus,
    input  CONTROL_PSR_OutBus
  );
endinterface

// File: rtl/control_microsequencer.sv
// Microprogrammed control unit: FETCH/LOAD/EXEC over a synchronous control-store ROM.
// Define MICROSEQ_MEMWAIT_EN to make EXEC wait on MemReady for memory microinstructions.
module control_microsequencer #(
  parameter int DATAWIDTH_MIR_DIRECTION = 6,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_DECODEROP     = 8,
  parameter int DATAWIDTH_CS_ADDRESS    = 11,
  parameter int DATAWIDTH_MICROWORD     = 41
) (
  input  logic                     CONTROL_CLOCK_50,
  input  logic                     CONTROL_RESET_InLow,
  control_microsequencer_if.master bus
);

  // Field positions, packed downward from the MSB of the microword.
  localparam int A_LO     = DATAWIDTH_MICROWORD - DATAWIDTH_MIR_DIRECTION;
  localparam int AMUX_BIT = A_LO - 1;
  localparam int B_LO     = AMUX_BIT - DATAWIDTH_MIR_DIRECTION;
  localparam int BMUX_BIT = B_LO - 1;
  localparam int C_LO     = BMUX_BIT - DATAWIDTH_MIR_DIRECTION;
  localparam int CMUX_BIT = C_LO - 1;
  localparam int RD_BIT   = CMUX_BIT - 1;
  localparam int WR_BIT   = RD_BIT - 1;
  localparam int ALU_LO   = WR_BIT - DATAWIDTH_ALU_SELECTION;
  localparam int COND_LO  = ALU_LO - 3;

  typedef enum logic [1:0] {FETCH, LOAD, EXEC} state_t;

  state_t                          state, state_next;
  logic [DATAWIDTH_CS_ADDRESS-1:0] csai, csai_next;
  logic [DATAWIDTH_MICROWORD-1:0]  mir, mir_next;
  logic [3:0]                      psr, psr_next;

  logic                            mir_rd, mir_wr, in_exec, mem_done, commit;
  logic [2:0]                      cond;
  logic [DATAWIDTH_CS_ADDRESS-1:0] jaddr, seq_addr, dispatch_addr, branch_addr;
  logic [DATAWIDTH_DECODEROP-1:0]  ops;

  assign mir_rd        = mir[RD_BIT];
  assign mir_wr        = mir[WR_BIT];
  assign cond          = mir[ALU_LO-1:COND_LO];
  assign jaddr         = mir[DATAWIDTH_CS_ADDRESS-1:0];
  assign ops           = bus.CONTROL_OPS_InBus;
  assign seq_addr      = csai + DATAWIDTH_CS_ADDRESS'(1);
  assign dispatch_addr = {1'b1, ops, 2'b00};
  assign in_exec       = (state == EXEC);

`ifdef MICROSEQ_MEMWAIT_EN
  logic mem_op;
  assign mem_op   = mir_rd | mir_wr;
  assign mem_done = ~mem_op | bus.CONTROL_MemReady_In;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.CONTROL_MemReady_In;
  assign mem_done         = 1'b1;
`endif

  assign commit = in_exec & mem_done;

  // psr only changes on the commit edge, so branches see the flags held at EXEC entry.
  always_comb begin
    branch_addr = seq_addr;
    case (cond)
      3'd1:    if (psr[3]) branch_addr = jaddr;
      3'd2:    if (psr[2]) branch_addr = jaddr;
      3'd3:    if (psr[1]) branch_addr = jaddr;
      3'd4:    if (psr[0]) branch_addr = jaddr;
      3'd5:    if (bus.CONTROL_Bit13_In) branch_addr = jaddr;
      3'd6:    branch_addr = jaddr;
      3'd7:    branch_addr = dispatch_addr;
      default: branch_addr = seq_addr;
    endcase
  end

  always_comb begin
    state_next = state;
    csai_next  = csai;
    mir_next   = mir;
    psr_next   = psr;
    case (state)
      FETCH: state_next = LOAD;
      LOAD: begin
        mir_next   = bus.CONTROL_MicroWord_InBus;
        state_next = EXEC;
      end
      EXEC: begin
        if (commit) begin
          csai_next  = branch_addr;
          state_next = FETCH;
          if (bus.CONTROL_SetCode_In)
            psr_next = {bus.CONTROL_FlagN_In, bus.CONTROL_FlagZ_In,
                        bus.CONTROL_FlagV_In, bus.CONTROL_FlagC_In};
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge CONTROL_CLOCK_50 or negedge CONTROL_RESET_InLow) begin
    if (!CONTROL_RESET_InLow) begin
      state <= FETCH;
      csai  <= '0;
      mir   <= '0;
      psr   <= '0;
    end else begin
      state <= state_next;
      csai  <= csai_next;
      mir   <= mir_next;
      psr   <= psr_next;
    end
  end

  // C-side write fields stay zeroed (register 0, ALU source) until the commit cycle.
  assign bus.CONTROL_CSAddress_OutBus    = csai;
  assign bus.CONTROL_DirA_OutBus         = mir[DATAWIDTH_MICROWORD-1:A_LO];
  assign bus.CONTROL_SelectA_Out         = mir[AMUX_BIT];
  assign bus.CONTROL_DirB_OutBus         = mir[AMUX_BIT-1:B_LO];
  assign bus.CONTROL_SelectB_Out         = mir[BMUX_BIT];
  assign bus.CONTROL_DirC_OutBus         = commit ? mir[BMUX_BIT-1:C_LO] : '0;
  assign bus.CONTROL_SelectC_Out         = commit & mir[CMUX_BIT];
  assign bus.CONTROL_RD_Out              = commit & mir_rd & ~mir_wr;
  assign bus.CONTROL_ALUOperation_OutBus = mir[WR_BIT-1:ALU_LO];
  assign bus.CONTROL_MemRead_Out         = in_exec & mir_rd & ~mir_wr;
  assign bus.CONTROL_MemWrite_Out        = in_exec & mir_wr;
  assign bus.CONTROL_PSR_OutBus          = psr;

endmodule

// File: tb/tb_control_microsequencer.sv
// Self-checking bench for control_microsequencer: directed scenarios plus random microwords
// checked against a behavioural model of the microsequencing rules.
module tb_control_microsequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_microsequencer_if bus ();

  control_microsequencer dut (
    .CONTROL_CLOCK_50    (clk),
    .CONTROL_RESET_InLow (rst_n),
    .bus                 (bus)
  );

  logic [40:0] rom [2048];
  logic [40:0] rom_q;
  always @(posedge clk) rom_q <= rom[bus.CONTROL_CSAddress_OutBus];
  assign bus.CONTROL_MicroWord_InBus = rom_q;

  int checks = 0;
  int failures = 0;

  logic [10:0] m_csai;
  logic [3:0]  m_psr;
  logic [40:0] m_prev;

  logic [10:0] o_fetch_cs, o_next_cs;
  logic [5:0]  o_dira_fetch, o_dira, o_dirb, o_dirc;
  logic        o_sela, o_selb, o_selc, o_rd, o_strobe_after;
  logic [3:0]  o_alu, o_psr;
  int          o_reads, o_writes, o_null_bad;

  function automatic logic [40:0] mk_word(input logic [5:0] a, input logic amux,
                                          input logic [5:0] b, input logic bmux,
                                          input logic [5:0] c, input logic cmux,
                                          input logic rd, input logic wr, input logic [3:0] alu,
                                          input logic [2:0] cond, input logic [10:0] jaddr);
    return {a, amux, b, bmux, c, cmux, rd, wr, alu, cond, jaddr};
  endfunction

  function automatic int exec_len(input logic [40:0] w, input int waits);
`ifdef MICROSEQ_MEMWAIT_EN
    if (w[19] | w[18]) return waits + 1;
`endif
    return 1;
  endfunction

  function automatic logic [10:0] model_next(input logic [10:0] csai, input logic [40:0] w,
                                             input logic [3:0] psr, input logic bit13,
                                             input logic [7:0] ops);
    int seq, jump, disp;
    seq  = (int'(csai) + 1) % 2048;
    jump = int'(w[10:0]);
    disp = 1024 + 4 * int'(ops);
    case (w[13:11])
      3'd0:    return 11'(seq);
      3'd1:    return psr[3] ? 11'(jump) : 11'(seq);
      3'd2:    return psr[2] ? 11'(jump) : 11'(seq);
      3'd3:    return psr[1] ? 11'(jump) : 11'(seq);
      3'd4:    return psr[0] ? 11'(jump) : 11'(seq);
      3'd5:    return bit13 ? 11'(jump) : 11'(seq);
      3'd6:    return 11'(jump);
      default: return 11'(disp);
    endcase
  endfunction

  task automatic model_commit(input logic [40:0] w, input logic setcode, input logic [3:0] flags,
                              input logic bit13, input logic [7:0] ops);
    m_csai = model_next(m_csai, w, m_psr, bit13, ops);
    if (setcode) m_psr = flags;
    m_prev = w;
  endtask

  // Runs the microword at rom[m_csai] from FETCH to the next FETCH, recording observations.
  // Non-commit cycles drive SetCode=1 with inverted flags to expose any early PSR update.
  task automatic exec_uinstr(input int waits, input logic setcode, input logic [3:0] flags,
                             input logic bit13, input logic [7:0] ops);
    logic [40:0] w;
    int          len;
    logic        last;
    w = rom[m_csai];
    len = exec_len(w, waits);
    o_reads = 0;
    o_writes = 0;
    o_null_bad = 0;
    bus.CONTROL_Bit13_In = bit13;
    bus.CONTROL_OPS_InBus = ops;
    for (int cyc = 0; cyc < len + 2; cyc++) begin
      if (cyc > 0) @(negedge clk);
      last = (cyc == len + 1);
      bus.CONTROL_SetCode_In = last ? setcode : 1'b1;
      {bus.CONTROL_FlagN_In, bus.CONTROL_FlagZ_In, bus.CONTROL_FlagV_In, bus.CONTROL_FlagC_In} =
        last ? flags : ~flags;
      if (cyc < 2) bus.CONTROL_MemReady_In = 1'b1;
      else if (w[19] | w[18]) bus.CONTROL_MemReady_In = ((cyc - 2) >= waits);
      else bus.CONTROL_MemReady_In = 1'($urandom_range(0, 1));
      #1;
      if (cyc == 0) begin
        o_fetch_cs = bus.CONTROL_CSAddress_OutBus;
        o_dira_fetch = bus.CONTROL_DirA_OutBus;
      end
      if (bus.CONTROL_MemRead_Out === 1'b1) o_reads++;
      if (bus.CONTROL_MemWrite_Out === 1'b1) o_writes++;
      if (!last && ({bus.CONTROL_DirC_OutBus, bus.CONTROL_SelectC_Out, bus.CONTROL_RD_Out} !== 8'd0))
        o_null_bad++;
      if (last) begin
        o_dirc = bus.CONTROL_DirC_OutBus;
        o_selc = bus.CONTROL_SelectC_Out;
        o_rd   = bus.CONTROL_RD_Out;
        o_dira = bus.CONTROL_DirA_OutBus;
        o_sela = bus.CONTROL_SelectA_Out;
        o_dirb = bus.CONTROL_DirB_OutBus;
        o_selb = bus.CONTROL_SelectB_Out;
        o_alu  = bus.CONTROL_ALUOperation_OutBus;
      end
    end
    @(negedge clk);
    bus.CONTROL_SetCode_In = 1'b0;
    bus.CONTROL_MemReady_In = 1'b1;
    #1;
    o_next_cs = bus.CONTROL_CSAddress_OutBus;
    o_psr = bus.CONTROL_PSR_OutBus;
    o_strobe_after = bus.CONTROL_MemRead_Out | bus.CONTROL_MemWrite_Out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (bus.CONTROL_CSAddress_OutBus !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_csaddr: got=%h expected=000", bus.CONTROL_CSAddress_OutBus);
    end
    checks++;
    if (bus.CONTROL_PSR_OutBus !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_psr: got=%b expected=0000", bus.CONTROL_PSR_OutBus);
    end
    checks++;
    if ({bus.CONTROL_DirA_OutBus, bus.CONTROL_SelectA_Out, bus.CONTROL_DirB_OutBus,
         bus.CONTROL_SelectB_Out, bus.CONTROL_DirC_OutBus, bus.CONTROL_SelectC_Out,
         bus.CONTROL_RD_Out, bus.CONTROL_ALUOperation_OutBus, bus.CONTROL_MemRead_Out,
         bus.CONTROL_MemWrite_Out} !== 29'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got nonzero datapath/strobe outputs, expected all 0");
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_sequence();
    logic [40:0] w;
    w = mk_word(6'd3, 1'b0, 6'd4, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 4'd9, 3'd0, 11'd0);
    rom[m_csai] = w;
    exec_uinstr(0, 1'b0, 4'b0000, 1'b0, 8'h00);
    checks++;
    if (o_fetch_cs !== 11'd0) begin
      failures++; $display("[TB] FAIL seq_fetch_addr: got=%h expected=000", o_fetch_cs);
    end
    checks++;
    if (o_null_bad != 0) begin
      failures++; $display("[TB] FAIL seq_c_nullify: got=%0d bad cycles expected=0", o_null_bad);
    end
    checks++;
    if (o_dirc !== 6'd5) begin
      failures++; $display("[TB] FAIL seq_dirc_commit: got=%0d expected=5", o_dirc);
    end
    checks++;
    if ({o_dira, o_sela, o_dirb, o_selb, o_alu} !== {6'd3, 1'b0, 6'd4, 1'b1, 4'd9}) begin
      failures++; $display("[TB] FAIL seq_exec_fields: got=%h expected=%h",
                           {o_dira, o_sela, o_dirb, o_selb, o_alu}, {6'd3, 1'b0, 6'd4, 1'b1, 4'd9});
    end
    checks++;
    if (o_next_cs !== 11'd1) begin
      failures++; $display("[TB] FAIL seq_next_addr: got=%h expected=001", o_next_cs);
    end
    checks++;
    if (o_psr !== 4'd0) begin
      failures++; $display("[TB] FAIL seq_psr_hold: got=%b expected=0000", o_psr);
    end
    model_commit(w, 1'b0, 4'b0000, 1'b0, 8'h00);
  endtask

  task automatic test_branch();
    logic [40:0] w;
    w = mk_word(6'd1, 1'b0, 6'd2, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd3, 3'd0, 11'h000);
    rom[m_csai] = w;
    exec_uinstr(0, 1'b1, 4'b0100, 1'b0, 8'h00);
    checks++;
    if (o_psr !== 4'b0100) begin
      failures++; $display("[TB] FAIL branch_psr_set: got=%b expected=0100", o_psr);
    end
    model_commit(w, 1'b1, 4'b0100, 1'b0, 8'h00);
    w = mk_word(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd2, 11'h100);
    rom[m_csai] = w;
    exec_uinstr(0, 1'b0, 4'b0000, 1'b0, 8'h00);
    checks++;
    if (o_next_cs !== 11'h100) begin
      failures++; $display("[TB] FAIL branch_z_taken: got=%h expected=100", o_next_cs);
    end
    model_commit(w, 1'b0, 4'b0000, 1'b0, 8'h00);
    // Clears Z in the same microinstruction that branches on it: old Z must still win.
    w = mk_word(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd2, 11'h200);
    rom[m_csai] = w;
    exec_uinstr(0, 1'b1, 4'b0000, 1'b0, 8'h00);
    checks++;
    if ({o_next_cs, o_psr} !== {11'h200, 4'b0000}) begin
      failures++; $display("[TB] FAIL branch_old_psr: got=%h/%b expected=200/0000", o_next_cs, o_psr);
    end
    model_commit(w, 1'b1, 4'b0000, 1'b0, 8'h00);
  endtask

  task automatic test_dispatch();
    logic [40:0] w;
    w = mk_word(6'd7, 1'b1, 6'd8, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd1, 3'd7, 11'h123);
    rom[m_csai] = w;
    exec_uinstr(0, 1'b0, 4'b0000, 1'b0, 8'h81);
    checks++;
    if (o_next_cs !== 11'h604) begin
      failures++; $display("[TB] FAIL dispatch_addr: got=%h expected=604", o_next_cs);
    end
    model_commit(w, 1'b0, 4'b0000, 1'b0, 8'h81);
  endtask

  task automatic test_memwait();
    logic [40:0] w;
    int exp_reads;
`ifdef MICROSEQ_MEMWAIT_EN
    exp_reads = 5;
`else
    exp_reads = 1;
`endif
    w = mk_word(6'd2, 1'b0, 6'd3, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0, 4'd5, 3'd0, 11'h000);
    rom[m_csai] = w;
    exec_uinstr(4, 1'b0, 4'b0000, 1'b0, 8'h00);
    checks++;
    if (o_reads != exp_reads || o_writes != 0) begin
      failures++; $display("[TB] FAIL memwait_strobes: got reads=%0d writes=%0d expected reads=%0d writes=0",
                           o_reads, o_writes, exp_reads);
    end
    checks++;
    if (o_null_bad != 0) begin
      failures++; $display("[TB] FAIL memwait_nullify: got=%0d bad cycles expected=0", o_null_bad);
    end
    checks++;
    if ({o_dirc, o_selc, o_rd} !== {6'd7, 1'b1, 1'b1}) begin
      failures++; $display("[TB] FAIL memwait_commit: got=%h expected=%h", {o_dirc, o_selc, o_rd}, {6'd7, 1'b1, 1'b1});
    end
    checks++;
    if (o_next_cs !== 11'h605 || o_strobe_after !== 1'b0) begin
      failures++; $display("[TB] FAIL memwait_next: got=%h strobe=%b expected=605 strobe=0", o_next_cs, o_strobe_after);
    end
    model_commit(w, 1'b0, 4'b0000, 1'b0, 8'h00);
  endtask

  task automatic test_rdwr_conflict();
    logic [40:0] w;
    int exp_writes;
    w = mk_word(6'd1, 1'b0, 6'd1, 1'b0, 6'd9, 1'b0, 1'b1, 1'b1, 4'd2, 3'd0, 11'h000);
    exp_writes = exec_len(w, 2);
    rom[m_csai] = w;
    exec_uinstr(2, 1'b0, 4'b0000, 1'b0, 8'h00);
    checks++;
    if (o_writes != exp_writes || o_reads != 0) begin
      failures++; $display("[TB] FAIL rdwr_strobes: got writes=%0d reads=%0d expected writes=%0d reads=0",
                           o_writes, o_reads, exp_writes);
    end
    checks++;
    if ({o_dirc, o_rd} !== {6'd9, 1'b0}) begin
      failures++; $display("[TB] FAIL rdwr_commit: got dirc=%0d rd=%b expected dirc=9 rd=0", o_dirc, o_rd);
    end
    model_commit(w, 1'b0, 4'b0000, 1'b0, 8'h00);
  endtask

  task automatic test_wrap();
    logic [40:0] w;
    w = mk_word(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd6, 11'h7FF);
    rom[m_csai] = w;
    exec_uinstr(0, 1'b0, 4'b0000, 1'b0, 8'h00);
    checks++;
    if (o_next_cs !== 11'h7FF) begin
      failures++; $display("[TB] FAIL wrap_jump: got=%h expected=7ff", o_next_cs);
    end
    model_commit(w, 1'b0, 4'b0000, 1'b0, 8'h00);
    w = mk_word(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 11'h055);
    rom[m_csai] = w;
    exec_uinstr(0, 1'b0, 4'b0000, 1'b0, 8'h00);
    checks++;
    if (o_next_cs !== 11'h000) begin
      failures++; $display("[TB] FAIL wrap_increment: got=%h expected=000", o_next_cs);
    end
    model_commit(w, 1'b0, 4'b0000, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [40:0] w;
    logic [10:0] exp_next;
    logic [3:0]  exp_psr, flags;
    logic [7:0]  ops;
    logic        setcode, bit13;
    int          waits, len;
    for (int it = 0; it < 40; it++) begin
      r = {$urandom, $urandom};
      w = r[40:0];
      waits = $urandom_range(0, 3);
      setcode = 1'($urandom_range(0, 1));
      flags = 4'($urandom_range(0, 15));
      bit13 = 1'($urandom_range(0, 1));
      ops = 8'($urandom_range(0, 255));
      rom[m_csai] = w;
      len = exec_len(w, waits);
      exp_next = model_next(m_csai, w, m_psr, bit13, ops);
      exp_psr = setcode ? flags : m_psr;
      exec_uinstr(waits, setcode, flags, bit13, ops);
      checks++;
      if (o_fetch_cs !== m_csai || o_dira_fetch !== m_prev[40:35]) begin
        failures++; $display("[TB] FAIL random_fetch it=%0d: got addr=%h dira=%0d expected addr=%h dira=%0d",
                             it, o_fetch_cs, o_dira_fetch, m_csai, m_prev[40:35]);
      end
      checks++;
      if ({o_dira, o_sela, o_dirb, o_selb, o_alu} !== {w[40:35], w[34], w[33:28], w[27], w[17:14]}) begin
        failures++; $display("[TB] FAIL random_exec_fields it=%0d: got=%h expected=%h", it,
                             {o_dira, o_sela, o_dirb, o_selb, o_alu}, {w[40:35], w[34], w[33:28], w[27], w[17:14]});
      end
      checks++;
      if ({o_dirc, o_selc, o_rd} !== {w[26:21], w[20], w[19] & ~w[18]} || o_null_bad != 0) begin
        failures++; $display("[TB] FAIL random_cwrite it=%0d: got=%h early=%0d expected=%h early=0", it,
                             {o_dirc, o_selc, o_rd}, o_null_bad, {w[26:21], w[20], w[19] & ~w[18]});
      end
      checks++;
      if (o_reads != ((w[19] & ~w[18]) ? len : 0) || o_writes != (w[18] ? len : 0) || o_strobe_after !== 1'b0) begin
        failures++; $display("[TB] FAIL random_strobes it=%0d: got reads=%0d writes=%0d after=%b rd=%b wr=%b len=%0d",
                             it, o_reads, o_writes, o_strobe_after, w[19], w[18], len);
      end
      checks++;
      if (o_next_cs !== exp_next || o_psr !== exp_psr) begin
        failures++; $display("[TB] FAIL random_next it=%0d: got addr=%h psr=%b expected addr=%h psr=%b cond=%0d",
                             it, o_next_cs, o_psr, exp_next, exp_psr, w[13:11]);
      end
      model_commit(w, setcode, flags, bit13, ops);
    end
  endtask

  task automatic test_reset_midwait();
    logic [40:0] w;
    w = mk_word(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd6, 11'h2A5);
    rom[m_csai] = w;
    exec_uinstr(0, 1'b1, 4'b1011, 1'b0, 8'h00);
    model_commit(w, 1'b1, 4'b1011, 1'b0, 8'h00);
    w = mk_word(6'd4, 1'b0, 6'd5, 1'b0, 6'd6, 1'b0, 1'b1, 1'b0, 4'd7, 3'd0, 11'h000);
    rom[m_csai] = w;
    bus.CONTROL_SetCode_In = 1'b0;
    bus.CONTROL_MemReady_In = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.CONTROL_MemReady_In = 1'b0;
    #1;
`ifdef MICROSEQ_MEMWAIT_EN
    @(negedge clk);
    #1;
`endif
    checks++;
    if ({bus.CONTROL_MemRead_Out, bus.CONTROL_CSAddress_OutBus, bus.CONTROL_PSR_OutBus} !== {1'b1, 11'h2A5, 4'b1011}) begin
      failures++; $display("[TB] FAIL midwait_before_reset: got read=%b addr=%h psr=%b expected read=1 addr=2a5 psr=1011",
                           bus.CONTROL_MemRead_Out, bus.CONTROL_CSAddress_OutBus, bus.CONTROL_PSR_OutBus);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.CONTROL_MemRead_Out, bus.CONTROL_MemWrite_Out, bus.CONTROL_CSAddress_OutBus, bus.CONTROL_PSR_OutBus} !== 17'd0) begin
      failures++; $display("[TB] FAIL midwait_reset: got read=%b write=%b addr=%h psr=%b expected all 0",
                           bus.CONTROL_MemRead_Out, bus.CONTROL_MemWrite_Out, bus.CONTROL_CSAddress_OutBus,
                           bus.CONTROL_PSR_OutBus);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.CONTROL_MemReady_In = 1'b1;
    #1;
    m_csai = 11'd0;
    m_psr = 4'd0;
    m_prev = 41'd0;
  endtask

  task automatic test_back_to_back();
    logic [40:0] w0, w1;
    w0 = mk_word(6'd9, 1'b1, 6'd10, 1'b0, 6'd11, 1'b1, 1'b0, 1'b0, 4'd6, 3'd0, 11'h000);
    w1 = mk_word(6'd12, 1'b0, 6'd13, 1'b1, 6'd14, 1'b0, 1'b0, 1'b0, 4'd8, 3'd0, 11'h000);
    rom[0] = w0;
    rom[1] = w1;
    exec_uinstr(0, 1'b0, 4'b0000, 1'b0, 8'h00);
    checks++;
    if ({o_fetch_cs, o_dira_fetch, o_next_cs} !== {11'd0, 6'd0, 11'd1}) begin
      failures++; $display("[TB] FAIL b2b_first: got addr=%h dira=%0d next=%h expected 000/0/001",
                           o_fetch_cs, o_dira_fetch, o_next_cs);
    end
    model_commit(w0, 1'b0, 4'b0000, 1'b0, 8'h00);
    exec_uinstr(0, 1'b0, 4'b0000, 1'b0, 8'h00);
    checks++;
    if ({o_fetch_cs, o_dira_fetch, o_dirc, o_next_cs} !== {11'd1, 6'd9, 6'd14, 11'd2}) begin
      failures++; $display("[TB] FAIL b2b_second: got addr=%h dira=%0d dirc=%0d next=%h expected 001/9/14/002",
                           o_fetch_cs, o_dira_fetch, o_dirc, o_next_cs);
    end
    model_commit(w1, 1'b0, 4'b0000, 1'b0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 41'd0;
    bus.CONTROL_MemReady_In = 1'b1;
    bus.CONTROL_SetCode_In = 1'b0;
    bus.CONTROL_FlagN_In = 1'b0;
    bus.CONTROL_FlagZ_In = 1'b0;
    bus.CONTROL_FlagV_In = 1'b0;
    bus.CONTROL_FlagC_In = 1'b0;
    bus.CONTROL_Bit13_In = 1'b0;
    bus.CONTROL_OPS_InBus = 8'h00;
    m_csai = 11'd0;
    m_psr = 4'd0;
    m_prev = 41'd0;
    test_reset();
    test_sequence();
    test_branch();
    test_dispatch();
    test_memwait();
    test_rdwr_conflict();
    test_wrap();
    test_random();
    test_reset_midwait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
